or_arb_sched: RTL and testbench
===============================

# or_arb_sched

Round-robin scheduler that shares one registered bitwise-OR datapath among N requesters. Each requester offers an operand pair with a valid/ready handshake. The scheduler grants one requester per cycle, computes `a | b` in a single pipeline stage, and returns the result tagged with the requester index. The result handshake supports backpressure. The block sits between the requester ports and the shared OR unit, and is the only path into that unit.

## Interface
- `N`, 4: number of requesters (2..16).
- `W`, 8: operand and result width in bits.
- `IDW`, 2: width of the requester index; must equal clog2(N).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N: bit i means requester i offers an operand pair.
- `req_a` in N*W: operand A; requester i occupies bits [i*W +: W].
- `req_b` in N*W: operand B, packed the same way as `req_a`.
- `req_ready` in/out, out N: one-hot grant; bit i high means requester i's pair is accepted this cycle.
- `resp_valid` out 1: result register holds a valid result.
- `resp_data` out W: registered `a | b`.
- `resp_id` out IDW: index of the requester that owns `resp_data`.
- `resp_ready` in 1: downstream consumer accepts the result.
- `op_count` out 16: completed-operation count; present only with `OR_ARB_CNT_EN`.

## Operation
- Output states: EMPTY (`resp_valid` = 0) and FULL (`resp_valid` = 1).
- Acceptance condition: `can_accept` = EMPTY, or (FULL and `resp_ready`).
- Grant rule: when `can_accept` is high and any `req_valid` bit is set, exactly one `req_ready` bit goes high.
  - The granted requester is the first valid index found searching upward from `last+1`, wrapping modulo N.
- `last` updates to the granted index only on an accepted handshake (`req_valid[i]` and `req_ready[i]`).
- `req_ready` is combinational from `req_valid`, `last`, `resp_valid` and `resp_ready`. It must not depend on `req_a` or `req_b`.
- On accept:
  - `resp_data` ← `req_a[i] | req_b[i]` (full W bits; no width change).
  - `resp_id` ← i.
  - State → FULL.
- Response completes when FULL and `resp_ready`:
  - If no new accept occurs in the same cycle, the state goes to EMPTY.
  - If a new accept occurs in the same cycle, the state stays FULL with the new data (back-to-back operation).
- FULL and not `resp_ready`: all `req_ready` bits are 0, and `resp_data` and `resp_id` hold stable.
- No valid requests: all `req_ready` bits are 0 and `last` is unchanged.
- A requester that drops `req_valid` before it is granted loses nothing. It simply re-enters arbitration when it raises `req_valid` again.

## Timing
- Reset values: `resp_valid` = 0, `resp_data` = 0, `resp_id` = 0, `last` = N-1 (so the first grant search starts at index 0), `op_count` = 0. `req_ready` = 0 while `rst` is high.
- Latency: an accept in cycle T produces `resp_valid` = 1 with its data in cycle T+1.
- Throughput: one result per cycle while `resp_ready` stays high.
- Fairness: if all N requesters hold `req_valid` continuously and `resp_ready` is high, grants follow 0,1,…,N-1,0,… with each index granted once per N cycles.
- Reset mid-operation: a held result is discarded and the arbitration pointer returns to its reset value in the same edge.

## Configuration
- Macro: `OR_ARB_CNT_EN`.
- Defined:
  - Adds the `op_count` port.
  - The count increments by 1 on every completed response handshake (`resp_valid` and `resp_ready`).
  - It saturates at 16'hFFFF.
  - Reset clears it to 0.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

## Structure
- Shared package/include `or_arb_pkg` holds:
  - the state encoding constants (`ST_EMPTY` = 1'b0, `ST_FULL` = 1'b1);
  - the counter width constant `CNT_W` = 16;
  - the counter saturation value.
- One sub-module, `rr_pick`:
  - inputs: the N-bit request vector and the last-granted index;
  - outputs: a one-hot grant and its encoded index;
  - purely combinational;
  - unit-testable on its own.
- The OR datapath is a single combinational OR feeding the result register. No further hierarchy.

## Test plan
- Reset test: hold `rst` high for 2 cycles with all `req_valid` = 4'b1111. Required: `req_ready` = 0, `resp_valid` = 0, `resp_data` = 0. After release, the first grant goes to index 0.
- Single request: requester 2 offers `a` = 8'hA0, `b` = 8'h05 with `resp_ready` = 1. Required: `req_ready` = 4'b0100 in cycle T; `resp_valid` = 1, `resp_data` = 8'hA5, `resp_id` = 2 in cycle T+1.
- Fairness: all four requesters valid continuously for 8 cycles with `resp_ready` = 1. Required: `resp_id` sequence 0,1,2,3,0,1,2,3 and one result per cycle.
- Backpressure: hold `resp_ready` = 0 for 3 cycles while FULL with requests pending. Required: `req_ready` = 0, and `resp_data` and `resp_id` stable for those cycles. When `resp_ready` rises, the next grant and the completion happen in the same cycle.
- Wrap and skip: `last` = 3, only requester 1 valid. Required: requester 1 is granted. Then requesters 0 and 1 both valid. Required: requester 0 is skipped in favour of no one else; the order is 1→0 across successive cycles, i.e. requester 0 is granted next.
- Counter (`OR_ARB_CNT_EN`): preload `op_count` to 16'hFFFE by force, then complete 3 responses. Required: `op_count` reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/or_arb_sched_pkg.sv
// Shared constants for the round-robin OR scheduler: output state encoding and op counter sizing.
// Latency: n/a (constants only).
// Backpressure: n/a.
package or_arb_pkg;

    // Result register occupancy: EMPTY means resp_valid low, FULL means a result is held.
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    // Completed-operation counter sizing; the counter sticks at its maximum rather than wrapping.
    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/or_arb_sched_rr_pick.sv
// Round-robin picker: first set request bit searching upward from last+1, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx
);

    logic found;

    // Two passes: indices above last get priority, then wrap to indices at or below last.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i > int'(last))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = IDW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i <= int'(last))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/or_arb_sched.sv
// Round-robin scheduler sharing one registered a|b datapath among N requesters; optional op counter (OR_ARB_CNT_EN).
// Latency: accept in cycle T gives resp_valid with data in T+1; one result per cycle when resp_ready stays high.
// Backpressure: while a result is held and resp_ready is low, all req_ready bits stay low and the result holds.
module or_arb_sched
    import or_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic [N-1:0]     req_ready,
    output logic             resp_valid,
    output logic [W-1:0]     resp_data,
    output logic [IDW-1:0]   resp_id,
    input  logic             resp_ready
`ifdef OR_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0] op_count
`endif
);

    logic           state_q;
    logic           state_d;
    logic [IDW-1:0] last_q;
    logic [W-1:0]   data_q;
    logic [IDW-1:0] id_q;
    logic [N-1:0]   pick_grant;
    logic [IDW-1:0] pick_idx;
    logic           can_accept;
    logic           accept;
    logic [W-1:0]   or_dat;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req   (req_valid),
        .last  (last_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Grant only when the result slot is free or draining this cycle; never while in reset.
    always_comb begin
        can_accept = (state_q == ST_EMPTY) || resp_ready;
        req_ready  = (!rst && can_accept) ? pick_grant : '0;
        accept     = |req_ready;
    end

    // Next state: a new accept always refills; otherwise a completed response empties the slot.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && resp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Shared OR datapath, steered by the one-hot pick so operands never affect arbitration.
    always_comb begin
        or_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_grant[i]) begin
                or_dat = req_a[i*W +: W] | req_b[i*W +: W];
            end
        end
    end

    // Result register and arbitration pointer; both move only on an accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            last_q  <= IDW'(N - 1);
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= or_dat;
                id_q   <= pick_idx;
                last_q <= pick_idx;
            end
        end
    end

    assign resp_valid = (state_q == ST_FULL);
    assign resp_data  = data_q;
    assign resp_id    = id_q;

`ifdef OR_ARB_CNT_EN
    logic [CNT_W-1:0] op_cnt_q;

    // Count completed response handshakes, sticking at the maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt_q <= '0;
        end else if (resp_valid && resp_ready && (op_cnt_q != CNT_MAX)) begin
            op_cnt_q <= op_cnt_q + 1'b1;
        end
    end

    assign op_count = op_cnt_q;
`endif

endmodule

// File: tb/tb_or_arb_sched.sv
// Self-checking bench for or_arb_sched: directed table, fairness and counter sequences, random vs model.
// Latency: inputs driven 1 time unit after a rising edge, req_ready sampled 2 units later, outputs 1 unit after the next edge.
// Backpressure: resp_ready is driven from the stimulus.
module tb_or_arb_sched;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             resp_valid;
    logic [W-1:0]     resp_data;
    logic [IDW-1:0]   resp_id;
    logic             resp_ready;
`ifdef OR_ARB_CNT_EN
    logic [15:0]      op_count;
`endif

    or_arb_sched #(
        .N   (N),
        .W   (W),
        .IDW (IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_ready (resp_ready)
`ifdef OR_ARB_CNT_EN
        ,
        .op_count   (op_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [N-1:0] rdy_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample the combinational grant, then step past the edge.
    task automatic drive(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] a,
                         input logic [N*W-1:0] b, input logic rr);
        rst        = r;
        req_valid  = v;
        req_a      = a;
        req_b      = b;
        resp_ready = rr;
        #2;
        rdy_s = req_ready;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  v;
        logic [31:0] a;
        logic [31:0] b;
        logic        rr;
        logic [3:0]  e_rdy;
        logic        e_vld;
        logic [7:0]  e_dat;
        logic [1:0]  e_id;
    } vec_t;

    vec_t tbl[14];

    // Reference model state for the random phase.
    int          m_last;
    bit          m_full;
    logic [7:0]  m_dat;
    int          m_id;
    int          m_cnt;

    initial begin
        // reset x2, first grant to 0, single request on 2, drain, wrap/skip, backpressure x3, release, hold, drain
        tbl[0]  = '{1'b1, 4'hF, 32'h0,        32'h0,        1'b1, 4'h0, 1'b0, 8'h00, 2'd0};
        tbl[1]  = '{1'b1, 4'hF, 32'h0,        32'h0,        1'b1, 4'h0, 1'b0, 8'h00, 2'd0};
        tbl[2]  = '{1'b0, 4'hF, 32'h44332211, 32'h0,        1'b1, 4'h1, 1'b1, 8'h11, 2'd0};
        tbl[3]  = '{1'b0, 4'h4, 32'h00A00000, 32'h00050000, 1'b1, 4'h4, 1'b1, 8'hA5, 2'd2};
        tbl[4]  = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 4'h0, 1'b0, 8'hA5, 2'd2};
        tbl[5]  = '{1'b0, 4'h8, 32'h0F000000, 32'h30000000, 1'b1, 4'h8, 1'b1, 8'h3F, 2'd3};
        tbl[6]  = '{1'b0, 4'h2, 32'h00000C00, 32'h00000300, 1'b1, 4'h2, 1'b1, 8'h0F, 2'd1};
        tbl[7]  = '{1'b0, 4'h3, 32'h00000055, 32'h000000AA, 1'b1, 4'h1, 1'b1, 8'hFF, 2'd0};
        tbl[8]  = '{1'b0, 4'hF, 32'h44332211, 32'h0,        1'b0, 4'h0, 1'b1, 8'hFF, 2'd0};
        tbl[9]  = '{1'b0, 4'hF, 32'h44332211, 32'h0,        1'b0, 4'h0, 1'b1, 8'hFF, 2'd0};
        tbl[10] = '{1'b0, 4'hF, 32'h44332211, 32'h0,        1'b0, 4'h0, 1'b1, 8'hFF, 2'd0};
        tbl[11] = '{1'b0, 4'hF, 32'h44332211, 32'h0,        1'b1, 4'h2, 1'b1, 8'h22, 2'd1};
        tbl[12] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 4'h0, 1'b1, 8'h22, 2'd1};
        tbl[13] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 4'h0, 1'b0, 8'h22, 2'd1};

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int t = 0; t < 14; t++) begin
            drive(tbl[t].r, tbl[t].v, tbl[t].a, tbl[t].b, tbl[t].rr);
            chk($sformatf("tbl%0d req_ready", t), 32'(rdy_s), 32'(tbl[t].e_rdy));
            chk($sformatf("tbl%0d resp_valid", t), 32'(resp_valid), 32'(tbl[t].e_vld));
            chk($sformatf("tbl%0d resp_data", t), 32'(resp_data), 32'(tbl[t].e_dat));
            chk($sformatf("tbl%0d resp_id", t), 32'(resp_id), 32'(tbl[t].e_id));
        end

        // Fairness: all requesters valid for 8 cycles, result every cycle in index order.
        drive(1'b1, 4'hF, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'hF, 32'h44332211, 32'h80808080, 1'b1);
            chk($sformatf("fair%0d req_ready", i), 32'(rdy_s), 32'(4'b0001 << (i % 4)));
            chk($sformatf("fair%0d resp_valid", i), 32'(resp_valid), 32'd1);
            chk($sformatf("fair%0d resp_id", i), 32'(resp_id), 32'(i % 4));
            chk($sformatf("fair%0d resp_data", i), 32'(resp_data),
                32'(8'(32'h44332211 >> (8 * (i % 4))) | 8'h80));
        end

`ifdef OR_ARB_CNT_EN
        // Counter saturation: preload near the top, then complete three responses.
        drive(1'b1, 4'h0, 32'h0, 32'h0, 1'b1);
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("cnt reset", 32'(op_count), 32'h0);
        force dut.op_cnt_q = 16'hFFFE;
        #1;
        release dut.op_cnt_q;
        drive(1'b0, 4'h1, 32'h0, 32'h0, 1'b1);
        chk("cnt preload", 32'(op_count), 32'hFFFE);
        drive(1'b0, 4'h1, 32'h0, 32'h0, 1'b1);
        chk("cnt first", 32'(op_count), 32'hFFFF);
        drive(1'b0, 4'h1, 32'h0, 32'h0, 1'b1);
        chk("cnt sat1", 32'(op_count), 32'hFFFF);
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("cnt sat2", 32'(op_count), 32'hFFFF);
`endif

        // Random phase against the reference model; first cycle is a reset to align state.
        m_last = N - 1; m_full = 1'b0; m_dat = '0; m_id = 0; m_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            logic          r;
            logic [N-1:0]  v;
            logic [31:0]   a;
            logic [31:0]   b;
            logic          rr;
            int            g;
            logic [N-1:0]  e_rdy;
            r  = (c == 0) || ($urandom_range(63) == 0);
            v  = N'($urandom);
            a  = $urandom;
            b  = $urandom;
            rr = ($urandom_range(3) != 0);
            g  = -1;
            if (!r && (!m_full || rr)) begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_last + k) % N;
                    if (g < 0 && v[j]) g = j;
                end
            end
            e_rdy = (g >= 0) ? N'(1 << g) : '0;
            drive(r, v, a, b, rr);
            chk($sformatf("rnd%0d req_ready", c), 32'(rdy_s), 32'(e_rdy));
            if (r) begin
                m_full = 1'b0; m_dat = '0; m_id = 0; m_last = N - 1; m_cnt = 0;
            end else begin
                if (m_full && rr && m_cnt < 65535) m_cnt++;
                if (g >= 0) begin
                    m_full = 1'b1;
                    m_dat  = 8'(a >> (g * W)) | 8'(b >> (g * W));
                    m_id   = g;
                    m_last = g;
                end else if (m_full && rr) begin
                    m_full = 1'b0;
                end
            end
            chk($sformatf("rnd%0d resp_valid", c), 32'(resp_valid), 32'(m_full));
            chk($sformatf("rnd%0d resp_data", c), 32'(resp_data), 32'(m_dat));
            chk($sformatf("rnd%0d resp_id", c), 32'(resp_id), 32'(m_id));
`ifdef OR_ARB_CNT_EN
            chk($sformatf("rnd%0d op_count", c), 32'(op_count), 32'(m_cnt));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
